// File: rtl/gpio_uart_wb_bridge_if.sv
// Wishbone classic bus between the UART debug bridge (master) and the core (slave).
interface gpio_uart_wb_bridge_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/gpio_uart_wb_bridge.sv
// UART (8N1) command bridge acting as Wishbone classic master; replies with status/read data.
// Frames: cmd, 4 addr bytes, 4 data bytes (writes only), all MSB first.
module gpio_uart_wb_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WB_TIMEOUT   = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  uart_rx_i,
  output logic                  uart_tx_o,
  output logic [1:0]            uart_oeb_o,
  gpio_uart_wb_bridge_if.master wb,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WB_CYCLE, SEND_RESP, SEND_DATA} state_t;

  state_t         state, state_nxt;
  logic           rx_meta, rx_sync, rx_last, rx_active, rx_vld, rx_ferr;
  logic [CW-1:0]  rx_cnt, rx_lim;
  logic [3:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic           tx_active, tx_rdy, tx_vld;
  logic [CW-1:0]  tx_cnt;
  logic [3:0]     tx_bit;
  logic [9:0]     tx_frame;
  logic [7:0]     tx_byte, resp;
  logic           is_wr, sent;
  logic [1:0]     byte_cnt;
  logic [TW-1:0]  timer;
  logic [31:0]    rdata;

  assign uart_oeb_o = 2'b01;
  assign busy_o     = (state != IDLE);
  assign uart_tx_o  = tx_active ? tx_frame[0] : 1'b1;
  assign rx_lim     = (rx_bit == 4'd0) ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1);
  // Ready on the last stop-bit cycle so consecutive bytes leave with no idle gap.
  assign tx_rdy     = !tx_active || (tx_cnt == CW'(CLKS_PER_BIT - 1) && tx_bit == 4'd9);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      rx_meta <= 1'b1; rx_sync <= 1'b1; rx_last <= 1'b1;
      rx_active <= 1'b0; rx_vld <= 1'b0; rx_ferr <= 1'b0;
      rx_cnt <= '0; rx_bit <= '0; rx_shift <= '0;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_active) begin
        if (rx_last && !rx_sync) begin
          rx_active <= 1'b1;
          rx_cnt    <= '0;
          rx_bit    <= '0;
        end
      end else if (rx_cnt == rx_lim) begin
        rx_cnt <= '0;
        if (rx_bit == 4'd0) begin
          if (rx_sync) rx_active <= 1'b0;
          else         rx_bit    <= 4'd1;
        end else if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          if (rx_sync) rx_vld  <= 1'b1;
          else         rx_ferr <= 1'b1;
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      tx_active <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_frame <= '1;
    end else if (tx_vld && tx_rdy) begin
      tx_active <= 1'b1;
      tx_frame  <= {1'b1, tx_byte, 1'b0};
      tx_cnt    <= '0;
      tx_bit    <= '0;
    end else if (tx_active) begin
      if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_active <= 1'b0;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tx_vld    = 1'b0;
    tx_byte   = resp;
    case (state)
      IDLE: begin
        if (rx_ferr) state_nxt = SEND_RESP;
        else if (rx_vld)
          state_nxt = (rx_shift == 8'h01 || rx_shift == 8'h02) ? GET_ADDR : SEND_RESP;
      end
      GET_ADDR: begin
        if (rx_ferr) state_nxt = SEND_RESP;
        else if (rx_vld && byte_cnt == 2'd3) state_nxt = is_wr ? GET_DATA : WB_CYCLE;
      end
      GET_DATA: begin
        if (rx_ferr) state_nxt = SEND_RESP;
        else if (rx_vld && byte_cnt == 2'd3) state_nxt = WB_CYCLE;
      end
      WB_CYCLE: begin
        if (wb.wbm_ack_i || timer == TW'(WB_TIMEOUT - 1)) state_nxt = SEND_RESP;
      end
      SEND_RESP: begin
        if (!sent) begin
          tx_vld = 1'b1;
          if (tx_rdy && resp == 8'hA5 && !is_wr) state_nxt = SEND_DATA;
        end else if (!tx_active) begin
          state_nxt = IDLE;
        end
      end
      SEND_DATA: begin
        tx_byte = rdata[31:24];
        if (!sent) tx_vld = 1'b1;
        else if (!tx_active) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state <= IDLE; is_wr <= 1'b0; sent <= 1'b0; byte_cnt <= '0; timer <= '0;
      resp <= '0; rdata <= '0; err_o <= 1'b0;
      wb.wbm_cyc_o <= 1'b0; wb.wbm_stb_o <= 1'b0; wb.wbm_we_o <= 1'b0;
      wb.wbm_sel_o <= '0; wb.wbm_adr_o <= '0; wb.wbm_dat_o <= '0;
    end else begin
      state <= state_nxt;
      if (rx_ferr) err_o <= 1'b1;
      case (state)
        IDLE, GET_ADDR, GET_DATA: begin
          sent <= 1'b0;
          if (rx_ferr) begin
            resp <= 8'hFE;
          end else if (rx_vld) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (state == IDLE) begin
              is_wr    <= (rx_shift == 8'h01);
              byte_cnt <= '0;
              resp     <= 8'h3F;
            end else if (state == GET_ADDR) begin
              wb.wbm_adr_o <= {wb.wbm_adr_o[23:0], rx_shift};
            end else begin
              wb.wbm_dat_o <= {wb.wbm_dat_o[23:0], rx_shift};
            end
          end
        end
        WB_CYCLE: begin
          // Ack on the terminal-count edge still wins over the timeout.
          if (wb.wbm_ack_i) begin
            rdata <= wb.wbm_dat_i;
            resp  <= 8'hA5;
          end else if (timer == TW'(WB_TIMEOUT - 1)) begin
            resp  <= 8'hEE;
            err_o <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
          if (state_nxt != WB_CYCLE) begin
            wb.wbm_cyc_o <= 1'b0; wb.wbm_stb_o <= 1'b0;
            wb.wbm_we_o  <= 1'b0; wb.wbm_sel_o <= '0;
          end
        end
        SEND_RESP: begin
          if (!sent && tx_rdy) begin
            if (state_nxt == SEND_DATA) byte_cnt <= '0;
            else                        sent     <= 1'b1;
          end
        end
        SEND_DATA: begin
          if (!sent && tx_rdy) begin
            rdata    <= {rdata[23:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) sent <= 1'b1;
          end
        end
        default: ;
      endcase
      if (state != WB_CYCLE && state_nxt == WB_CYCLE) begin
        wb.wbm_cyc_o <= 1'b1; wb.wbm_stb_o <= 1'b1;
        wb.wbm_we_o  <= is_wr; wb.wbm_sel_o <= 4'hF;
        timer        <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gpio_uart_wb_bridge.sv
// Scoreboard bench: stimulus pushes expected TX bytes / Wishbone cycles, monitors pop and compare.
module tb_gpio_uart_wb_bridge;
  localparam int CPB = 8;
  localparam int TO  = 16;

  typedef struct { logic [7:0] val; bit b2b; } tx_exp_t;
  typedef struct {
    logic [31:0] adr; logic [31:0] dat; bit we; int len; int delay; logic [31:0] rdata;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx, busy, err;
  logic [1:0] oeb;
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  bit exp_err = 1'b0;
  tx_exp_t tx_q[$];
  wb_exp_t wb_q[$];

  gpio_uart_wb_bridge_if bus ();

  gpio_uart_wb_bridge #(.CLKS_PER_BIT(CPB), .WB_TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .uart_rx_i(rx), .uart_tx_o(tx),
    .uart_oeb_o(oeb), .wb(bus), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // TX monitor: decode each serial byte at bit centres and pop the scoreboard.
  logic [7:0] mon_b;
  int mon_t0, mon_last;
  tx_exp_t mon_e;
  initial begin
    mon_last = 0;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        mon_t0 = cyc_n;
        repeat (4) @(negedge clk);
        chk("tx_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop", {31'd0, tx}, 32'd1);
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte %h expected none", mon_b);
        end else begin
          mon_e = tx_q.pop_front();
          chk("tx_byte", {24'd0, mon_b}, {24'd0, mon_e.val});
          if (mon_e.b2b) chk("tx_gap", mon_t0 - mon_last, 10 * CPB);
        end
        mon_last = mon_t0;
      end
    end
  end

  // Wishbone slave: consumes one expected cycle per cyc rise, acks per its delay.
  wb_exp_t cur;
  bit cur_ok = 1'b0;
  bit in_cyc = 1'b0;
  int wcnt = 0;
  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (bus.wbm_cyc_o && !in_cyc) begin
        in_cyc = 1'b1; wcnt = 1;
        if (wb_q.size() == 0) begin
          cur_ok = 1'b0; checks++; errors++;
          $display("FAIL wb_unexpected: got cycle adr %h expected none", bus.wbm_adr_o);
        end else begin
          cur = wb_q.pop_front(); cur_ok = 1'b1;
          chk("wb_adr", bus.wbm_adr_o, cur.adr);
          chk("wb_we", {31'd0, bus.wbm_we_o}, {31'd0, cur.we});
          chk("wb_sel", {28'd0, bus.wbm_sel_o}, 32'hF);
          chk("wb_stb", {31'd0, bus.wbm_stb_o}, 32'd1);
          if (cur.we) chk("wb_dat_o", bus.wbm_dat_o, cur.dat);
        end
      end else if (bus.wbm_cyc_o && in_cyc) begin
        wcnt++;
        if (cur_ok) chk("wb_adr_stable", bus.wbm_adr_o, cur.adr);
      end else if (!bus.wbm_cyc_o && in_cyc) begin
        in_cyc = 1'b0;
        if (cur_ok && cur.len >= 0) chk("wb_cyc_len", wcnt, cur.len);
      end
      if (bus.wbm_ack_i) begin
        bus.wbm_ack_i = 1'b0;
      end else if (in_cyc && cur_ok && cur.delay >= 0 && wcnt == cur.delay + 1) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = cur.rdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_q.size() != 0 || busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++;
      $display("FAIL idle_timeout: got busy %b pending %0d expected idle", busy, tx_q.size());
    end
    repeat (4) @(negedge clk);
    chk("wb_pending", wb_q.size(), 0);
  endtask

  function automatic void push_tx(input logic [7:0] v, input bit b2b);
    tx_exp_t e;
    e.val = v; e.b2b = b2b;
    tx_q.push_back(e);
  endfunction

  // Reference model: derive the expected bus cycle and reply from the command rules.
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                         input int delay, input logic [31:0] rdata, input bit junk);
    wb_exp_t w;
    logic [7:0] fr[$];
    bit ok;
    fr.push_back(cmd);
    if (cmd == 8'h01 || cmd == 8'h02) begin
      ok = (delay >= 0) && (delay + 1 <= TO);
      w.adr = adr; w.dat = dat; w.we = (cmd == 8'h01);
      w.len = ok ? delay + 1 : TO; w.delay = delay; w.rdata = rdata;
      wb_q.push_back(w);
      for (int i = 3; i >= 0; i--) fr.push_back(8'((adr >> (8 * i)) & 32'hFF));
      if (cmd == 8'h01) for (int i = 3; i >= 0; i--) fr.push_back(8'((dat >> (8 * i)) & 32'hFF));
      push_tx(ok ? 8'hA5 : 8'hEE, 1'b0);
      if (ok && cmd == 8'h02)
        for (int i = 3; i >= 0; i--) push_tx(8'((rdata >> (8 * i)) & 32'hFF), 1'b1);
      if (!ok) exp_err = 1'b1;
    end else begin
      push_tx(8'h3F, 1'b0);
    end
    foreach (fr[i]) send_byte(fr[i], 1'b1);
    if (junk) send_byte(8'h7E, 1'b1);
    wait_idle();
    chk("err_o", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    bit seen;
    int n;
    wb_exp_t w;
    logic [7:0] c;
    int d;

    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("rst_we", {31'd0, bus.wbm_we_o}, 32'd0);
    chk("rst_sel", {28'd0, bus.wbm_sel_o}, 32'd0);
    chk("rst_adr", bus.wbm_adr_o, 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("oeb", {30'd0, oeb}, 32'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Write; a trailing byte lands during the response and must be dropped.
    run_txn(8'h01, 32'h1000_0004, 32'hDEAD_BEEF, 3, 32'h0, 1'b1);
    run_txn(8'h02, 32'h0000_0008, 32'h0, 2, 32'h1234_5678, 1'b0);
    run_txn(8'h02, 32'h0000_000C, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
    run_txn(8'h7E, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    // Glitch: short low pulse must not start a byte.
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      seen |= busy;
    end
    chk("glitch_busy", {31'd0, seen}, 32'd0);

    // Framing error in the address phase.
    push_tx(8'hFE, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_idle();
    exp_err = 1'b1;
    chk("ferr_err", {31'd0, err}, 32'd1);
    run_txn(8'h01, 32'h0000_0100, 32'h0BAD_F00D, 0, 32'h0, 1'b0);

    // Reset in the middle of a bus cycle.
    w.adr = 32'h0000_0200; w.dat = '0; w.we = 1'b0; w.len = -1; w.delay = -1; w.rdata = '0;
    wb_q.push_back(w);
    send_byte(8'h02, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(8'((w.adr >> (8 * i)) & 32'hFF), 1'b1);
    n = 0;
    while (!bus.wbm_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_cyc", {31'd0, bus.wbm_cyc_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cyc", {31'd0, bus.wbm_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, bus.wbm_stb_o}, 32'd0);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    exp_err = 1'b0;
    repeat (20) @(negedge clk);

    // Timeout sets the sticky error; it survives a later good read.
    run_txn(8'h02, 32'h0000_0300, 32'h0, -1, 32'h0, 1'b0);
    run_txn(8'h02, 32'h0000_0008, 32'h0, 1, 32'h8765_4321, 1'b0);

    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 9);
      if (n < 4) c = 8'h01;
      else if (n < 8) c = 8'h02;
      else begin
        c = 8'($urandom_range(0, 255));
        while (c == 8'h01 || c == 8'h02) c = 8'($urandom_range(0, 255));
      end
      d = $urandom_range(0, 20);
      if (d > 17) d = -1;
      run_txn(c, $urandom, $urandom, d, $urandom, 1'b0);
    end

    chk("tx_q_empty", tx_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
